edff_deser: RTL and testbench

Serial-to-parallel capture stage that sits directly downstream of the enable flip-flop (EDFFTR) data path. It samples the flip-flop's Q output as a serial bit stream, one bit per strobed clock, and assembles fixed-width words. An optional even-parity bit is checked per frame. Completed words are presented on a valid/ready output register with overrun detection.

---
 rtl/edff_deser_if.sv | 25 ++
 rtl/edff_deser.sv | 122 ++++++++++++
 tb/tb_edff_deser.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edff_deser_if.sv
// Bit-stream input and valid/ready word output of the EDFFTR deserializer.
// The slave side is the deserializer; the master side is its environment.
interface edff_deser_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             svalid;
  logic             sstart;
  logic             dready;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             perr;
  logic             ovf;
  logic [7:0]       ovf_cnt;

  modport master (
    output sin, svalid, sstart, dready,
    input  dout, dvalid, perr, ovf, ovf_cnt
  );

  modport slave (
    input  sin, svalid, sstart, dready,
    output dout, dvalid, perr, ovf, ovf_cnt
  );
endinterface

// File: rtl/edff_deser.sv
// Serial-to-parallel capture of the EDFFTR Q stream: strobed bits are assembled into
// WIDTH-bit words, optionally even-parity checked, and held in a valid/ready register.
module edff_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  edff_deser_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] shifted, first_word, word;
  logic [CW-1:0]    count, count_nxt;
  logic             complete, word_perr, accept;
  logic [WIDTH-1:0] dout;
  logic             dvalid, perr, ovf;
  logic [7:0]       ovf_cnt;

  always_comb begin
    first_word = '0;
    if (MSB_FIRST) begin
      shifted       = {shreg[WIDTH-2:0], bus.sin};
      first_word[0] = bus.sin;
    end else begin
      shifted             = {bus.sin, shreg[WIDTH-1:1]};
      first_word[WIDTH-1] = bus.sin;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    complete  = 1'b0;
    word      = shifted;
    word_perr = 1'b0;
    if (bus.svalid) begin
      if (bus.sstart) begin
        // A start strobe always opens a fresh frame, abandoning any partial one
        state_nxt = SHIFT;
        shreg_nxt = first_word;
        count_nxt = CW'(1);
      end else begin
        case (state)
          SHIFT: begin
            shreg_nxt = shifted;
            count_nxt = count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              if (PARITY_EN) begin
                state_nxt = PARITY;
              end else begin
                complete  = 1'b1;
                state_nxt = IDLE;
              end
            end
          end
          PARITY: begin
            complete  = 1'b1;
            word      = shreg;
            word_perr = (^shreg) ^ bus.sin;
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      count <= count_nxt;
    end
  end

  // A completed word is taken only if the output register is empty or being drained now
  assign accept = !dvalid || bus.dready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      dvalid  <= 1'b0;
      perr    <= 1'b0;
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      ovf <= 1'b0;
      if (dvalid && bus.dready) begin
        dvalid <= 1'b0;
      end
      if (complete) begin
        if (accept) begin
          dout   <= word;
          perr   <= word_perr;
          dvalid <= 1'b1;
        end else begin
          ovf <= 1'b1;
          if (ovf_cnt != 8'hFF) begin
            ovf_cnt <= ovf_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign bus.dout    = dout;
  assign bus.dvalid  = dvalid;
  assign bus.perr    = perr;
  assign bus.ovf     = ovf;
  assign bus.ovf_cnt = ovf_cnt;
endmodule

// File: tb/tb_edff_deser.sv
// Self-checking bench for edff_deser: three configurations share one stimulus stream
// and are compared against a frame-level model built from bit lists.
module tb_edff_deser;
  localparam int W = 8;

  logic clk, rst_n, sin, svalid, sstart, dready;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  edff_deser_if #(.WIDTH(W)) bus0 ();
  edff_deser_if #(.WIDTH(W)) bus1 ();
  edff_deser_if #(.WIDTH(W)) bus2 ();

  // cfg0: MSB first with parity, cfg1: MSB first without parity, cfg2: LSB first with parity
  edff_deser #(.WIDTH(W), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  edff_deser #(.WIDTH(W), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  edff_deser #(.WIDTH(W), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.sin = sin;  assign bus0.svalid = svalid;  assign bus0.sstart = sstart;  assign bus0.dready = dready;
  assign bus1.sin = sin;  assign bus1.svalid = svalid;  assign bus1.sstart = sstart;  assign bus1.dready = dready;
  assign bus2.sin = sin;  assign bus2.svalid = svalid;  assign bus2.sstart = sstart;  assign bus2.dready = dready;

  // Observed outputs packed as {dout[18:11], dvalid[10], perr[9], ovf[8], ovf_cnt[7:0]}
  logic [18:0] act [3];
  assign act[0] = {bus0.dout, bus0.dvalid, bus0.perr, bus0.ovf, bus0.ovf_cnt};
  assign act[1] = {bus1.dout, bus1.dvalid, bus1.perr, bus1.ovf, bus1.ovf_cnt};
  assign act[2] = {bus2.dout, bus2.dvalid, bus2.perr, bus2.ovf, bus2.ovf_cnt};

  typedef struct packed {
    logic       act;
    logic [3:0] len;
    logic [8:0] bits;
    logic [7:0] dout;
    logic       dvalid;
    logic       perr;
    logic       ovf;
    logic [7:0] cnt;
  } mstate_t;

  mstate_t ms [3];

  // Reference: collect the frame's bits as a list, then build the word once it is full
  function automatic mstate_t model_next(input mstate_t s, input int c, input logic v,
                                         input logic st, input logic b, input logic r);
    mstate_t    n;
    int         flen;
    logic       done;
    logic [7:0] w;
    logic       p;
    n     = s;
    n.ovf = 1'b0;
    flen  = (c == 1) ? 8 : 9;
    done  = 1'b0;
    w     = '0;
    p     = 1'b0;
    if (v && (st || s.act)) begin
      if (st) begin
        n.bits = '0;
        n.len  = '0;
        n.act  = 1'b1;
      end
      n.bits[n.len] = b;
      n.len         = n.len + 4'd1;
      if (int'(n.len) == flen) begin
        done  = 1'b1;
        n.act = 1'b0;
      end
    end
    if (done) begin
      for (int i = 0; i < 8; i++) begin
        if (c == 2) w[i] = n.bits[i];
        else        w[7-i] = n.bits[i];
      end
      p = (c == 1) ? 1'b0 : ((^w) ^ n.bits[8]);
    end
    if (s.dvalid && r) n.dvalid = 1'b0;
    if (done) begin
      if (!s.dvalid || r) begin
        n.dout   = w;
        n.perr   = p;
        n.dvalid = 1'b1;
      end else begin
        n.ovf = 1'b1;
        if (n.cnt != 8'hFF) n.cnt = n.cnt + 8'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) ms[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) ms[c] <= model_next(ms[c], c, svalid, sstart, sin, dready);
    end
  end

  function automatic logic [18:0] exp_vec(input int c);
    return {ms[c].dout, ms[c].dvalid, ms[c].perr, ms[c].ovf, ms[c].cnt};
  endfunction

  task automatic drive_cycle(input logic b, input logic v, input logic st, input logic r);
    sin    = b;
    svalid = v;
    sstart = st;
    dready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Gap cycles go before every bit but the first, so the call returns right after the last strobe
  task automatic send_frame(input logic [7:0] w, input logic par, input int gap, input logic r);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) repeat (gap) drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, r);
      drive_cycle((i < 8) ? w[7-i] : par, 1'b1, i == 0, r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sin = 1'b0; svalid = 1'b0; sstart = 1'b0; dready = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (act[c] !== 19'h0) begin n_fail++; $display("FAIL reset_state cfg%0d: got %h, expected %h", c, act[c], 19'h0); end
    end
    rst_n = 1'b1;
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (act[0][10] !== 1'b1) begin n_fail++; $display("FAIL reset_pre_dvalid: got %b, expected 1", act[0][10]); end
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (act[c] !== 19'h0) begin n_fail++; $display("FAIL reset_async cfg%0d: got %h, expected %h", c, act[c], 19'h0); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (act[c][10] !== 1'b0 || act[c] !== exp_vec(c)) begin
          n_fail++; $display("FAIL reset_no_start cfg%0d: got %h, expected %h", c, act[c], exp_vec(c));
        end
      end
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] wv;
    wv = 8'hA5;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      drive_cycle((i < 8) ? wv[7-i] : 1'b0, 1'b1, i == 0, 1'b1);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL good_model cfg%0d: got %h, expected %h", c, act[c], exp_vec(c)); end
      end
      if (i == 7) begin
        n_checks++;
        if (act[1][18:9] !== {8'hA5, 1'b1, 1'b0}) begin n_fail++; $display("FAIL good_noparity: got %h, expected %h", act[1][18:9], {8'hA5, 1'b1, 1'b0}); end
      end
    end
    n_checks++;
    if (act[0][18:9] !== {8'hA5, 1'b1, 1'b0}) begin n_fail++; $display("FAIL good_frame: got %h, expected %h", act[0][18:9], {8'hA5, 1'b1, 1'b0}); end
    n_checks++;
    if (act[2][18:9] !== {8'hA5, 1'b1, 1'b0}) begin n_fail++; $display("FAIL good_lsb: got %h, expected %h", act[2][18:9], {8'hA5, 1'b1, 1'b0}); end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (act[0][10] !== 1'b0) begin n_fail++; $display("FAIL good_one_cycle: got %b, expected 0", act[0][10]); end
  endtask

  task automatic test_parity_error();
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 0, 1'b1);
    n_checks++;
    if (act[0][18:9] !== {8'hA5, 1'b1, 1'b1}) begin n_fail++; $display("FAIL perr_frame: got %h, expected %h", act[0][18:9], {8'hA5, 1'b1, 1'b1}); end
    n_checks++;
    if (act[2][18:9] !== {8'hA5, 1'b1, 1'b1}) begin n_fail++; $display("FAIL perr_lsb: got %h, expected %h", act[2][18:9], {8'hA5, 1'b1, 1'b1}); end
    n_checks++;
    if (act[1][18:11] !== 8'hA5 || act[1][9] !== 1'b0) begin n_fail++; $display("FAIL perr_noparity: got %h, expected dout a5 perr 0", act[1]); end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL perr_model cfg%0d: got %h, expected %h", c, act[c], exp_vec(c)); end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] wv;
    wv = 8'h3C;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) repeat (2) drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      if (i == 8) begin
        n_checks++;
        if (act[0][10] !== 1'b0) begin n_fail++; $display("FAIL gapped_early: got %b, expected 0", act[0][10]); end
      end
      drive_cycle((i < 8) ? wv[7-i] : 1'b0, 1'b1, i == 0, 1'b1);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL gapped_model cfg%0d: got %h, expected %h", c, act[c], exp_vec(c)); end
      end
    end
    n_checks++;
    if (act[0][18:10] !== {8'h3C, 1'b1}) begin n_fail++; $display("FAIL gapped_frame: got %h, expected %h", act[0][18:10], {8'h3C, 1'b1}); end
    n_checks++;
    if (act[2][18:10] !== {8'h3C, 1'b1}) begin n_fail++; $display("FAIL gapped_lsb: got %h, expected %h", act[2][18:10], {8'h3C, 1'b1}); end
  endtask

  task automatic test_overrun();
    logic [7:0] wv;
    int         pulses0, pulses1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h11, 1'b0, int'($urandom_range(0, 1)), 1'b0);
    wv = 8'h22; pulses0 = 0; pulses1 = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 9) drive_cycle((i < 8) ? wv[7-i] : 1'b0, 1'b1, i == 0, 1'b0);
      else       drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (act[0][8]) pulses0++;
      if (act[1][8]) pulses1++;
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL ovr_model cfg%0d: got %h, expected %h", c, act[c], exp_vec(c)); end
      end
    end
    n_checks++;
    if (pulses0 != 1 || pulses1 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d/%0d, expected 1/1", pulses0, pulses1); end
    n_checks++;
    if (act[0][18:10] !== {8'h11, 1'b1} || act[0][7:0] !== 8'd1) begin n_fail++; $display("FAIL ovr_hold: got %h, expected dout 11 dvalid 1 cnt 1", act[0]); end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (act[0][10] !== 1'b0 || act[1][10] !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b%b, expected 00", act[0][10], act[1][10]); end
    for (int k = 0; k < 257; k++) begin
      wv = 8'($urandom);
      send_frame(wv, ^wv, 0, 1'b0);
      if (k == 253) begin
        n_checks++;
        if (act[0][7:0] !== 8'd254) begin n_fail++; $display("FAIL ovr_cnt254: got %0d, expected 254", act[0][7:0]); end
      end
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (act[c][7:0] !== 8'd255 || act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL ovr_saturate cfg%0d: got %h, expected cnt ff %h", c, act[c], exp_vec(c)); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] wv;
    int         ones, ovfs;
    logic [7:0] seen;
    wv = 8'h0F; ones = 0; ovfs = 0; seen = '0;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      if (i < 4)       drive_cycle(1'($urandom_range(0, 1)), 1'b1, i == 0, 1'b1);
      else if (i < 13) drive_cycle((i < 12) ? wv[11-i] : 1'b0, 1'b1, i == 4, 1'b1);
      else             drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (act[0][10]) begin ones++; seen = act[0][18:11]; end
      if (act[0][8]) ovfs++;
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL abort_model cfg%0d: got %h, expected %h", c, act[c], exp_vec(c)); end
      end
    end
    n_checks++;
    if (ones != 1 || ovfs != 0 || seen !== 8'h0F) begin n_fail++; $display("FAIL abort_restart: got %0d valid %0d ovf dout %h, expected 1 0 0f", ones, ovfs, seen); end
    n_checks++;
    if (act[2][18:11] !== 8'hF0) begin n_fail++; $display("FAIL abort_lsb: got %h, expected f0", act[2][18:11]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wx, wy, wz;
    wx = 8'($urandom); wy = 8'($urandom); wz = 8'($urandom);
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(wx, ^wx, 0, 1'b0);
    n_checks++;
    if (act[0][18:10] !== {wx, 1'b1}) begin n_fail++; $display("FAIL b2b_first: got %h, expected %h", act[0][18:10], {wx, 1'b1}); end
    for (int i = 0; i < 18; i++) begin
      if (i < 9) drive_cycle((i < 8) ? wy[7-i] : ^wy, 1'b1, i == 0, i == 8);
      else       drive_cycle((i < 17) ? wz[16-i] : ^wz, 1'b1, i == 9, 1'b1);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL b2b_model cfg%0d: got %h, expected %h", c, act[c], exp_vec(c)); end
      end
      if (i == 8) begin
        n_checks++;
        if (act[0][18:8] !== {wy, 3'b100}) begin n_fail++; $display("FAIL b2b_swap: got %h, expected %h", act[0][18:8], {wy, 3'b100}); end
      end
    end
    n_checks++;
    if (act[0][18:9] !== {wz, 2'b10}) begin n_fail++; $display("FAIL b2b_restart: got %h, expected %h", act[0][18:9], {wz, 2'b10}); end
  endtask

  task automatic test_random();
    logic v, st, r;
    for (int k = 0; k < 800; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 3) != 0);
      drive_cycle(1'($urandom_range(0, 1)), v, st, r);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (act[c] !== exp_vec(c)) begin n_fail++; $display("FAIL random cfg%0d cycle %0d: got %h, expected %h", c, k, act[c], exp_vec(c)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_gapped();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
